conv_capture: RTL and testbench

- Frame sink at the output end of the convolution stream.
- Accepts the 8-bit pixel/valid stream produced by the 3x1 convolution stage and stores each valid pixel sequentially in an internal frame buffer.
- Tracks output row/column position and signals frame completion.
- Provides a 1-cycle-latency random-access readback port so the host/display side can drain the result.

---
 rtl/conv_capture.sv | 148 ++++++++++++++
 tb/tb_conv_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_capture.sv
// Frame sink for the 3x1 convolution stream: stores valid pixels in sequence,
// tracks row/column, flags completion and offers a registered readback port.
module conv_capture #(
    parameter int W         = 220,
    parameter int H         = 220,
    parameter int FRAME_PIX = 47960,
    parameter int AW        = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [7:0]    i_pxl_in,
    input  logic          i_valid_in,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_ready,
    output logic [AW-1:0] o_pxl_count,
    output logic [AW-1:0] o_col,
    output logic [AW-1:0] o_row,
    output logic          o_overflow
);

    localparam int IW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_mem [0:FRAME_PIX-1];
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_frame_done;
    logic          r_overflow;
    logic [AW-1:0] r_pxl_count;
    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row;

    logic          w_accepting;
    logic          w_wr;
    logic          w_last;
    logic          w_arm;
    logic          w_rd_ok;
    logic          w_rd_in_range;

    assign w_accepting   = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_wr          = w_accepting && i_valid_in;
    assign w_last        = w_wr && (r_pxl_count == AW'(FRAME_PIX - 1));
    assign w_arm         = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd_ok       = i_rd_en && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd_in_range = {1'b0, i_rd_addr} < (AW + 1)'(FRAME_PIX);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_ARMED;
            S_ARMED:   if (i_valid_in) w_next = w_last ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (w_last) w_next = S_DONE;
            S_DONE:    if (i_start) w_next = S_ARMED;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = 1'b0;
        o_ready = 1'b0;
        case (r_state)
            S_ARMED, S_CAPTURE: o_busy  = 1'b1;
            S_DONE:             o_ready = 1'b1;
            default:            ;
        endcase
    end

    // Buffer has no reset; its contents survive re-arming by design.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_pxl_count[IW-1:0]] <= i_pxl_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pxl_count  <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_arm) begin
                r_pxl_count <= '0;
                r_col       <= '0;
                r_row       <= '0;
                r_overflow  <= 1'b0;
            end else if (w_wr) begin
                r_pxl_count <= r_pxl_count + 1'b1;
                if (r_col == AW'(W - 1)) begin
                    r_col <= '0;
                    if (r_row != AW'(H - 1)) begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else if ((r_state == S_DONE) && i_valid_in) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Out-of-range addresses read back as zero rather than aliasing.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr[IW-1:0]] : 8'h00;
            end
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;
    assign o_pxl_count  = r_pxl_count;
    assign o_col        = r_col;
    assign o_row        = r_row;

endmodule

// File: tb/tb_conv_capture.sv
// Scoreboard bench for conv_capture: full-size frame on one instance and a
// small gapped frame (W=4, FRAME_PIX=10) on a second instance.
module tb_conv_capture;

    localparam int FP_A = 47960;
    localparam int FP_B = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- instance A: default parameters
    logic        a_reset, a_start, a_valid, a_rd_en;
    logic [7:0]  a_pxl;
    logic [15:0] a_rd_addr;
    logic [7:0]  a_rd_data;
    logic        a_rd_valid, a_busy, a_frame_done, a_ready, a_overflow;
    logic [15:0] a_pxl_count, a_col, a_row;

    conv_capture u_a (
        .i_clk       (clk),
        .i_reset     (a_reset),
        .i_start     (a_start),
        .i_pxl_in    (a_pxl),
        .i_valid_in  (a_valid),
        .i_rd_en     (a_rd_en),
        .i_rd_addr   (a_rd_addr),
        .o_rd_data   (a_rd_data),
        .o_rd_valid  (a_rd_valid),
        .o_busy      (a_busy),
        .o_frame_done(a_frame_done),
        .o_ready     (a_ready),
        .o_pxl_count (a_pxl_count),
        .o_col       (a_col),
        .o_row       (a_row),
        .o_overflow  (a_overflow)
    );

    // ---------------- instance B: small frame
    logic        b_reset, b_start, b_valid, b_rd_en;
    logic [7:0]  b_pxl;
    logic [15:0] b_rd_addr;
    logic [7:0]  b_rd_data;
    logic        b_rd_valid, b_busy, b_frame_done, b_ready, b_overflow;
    logic [15:0] b_pxl_count, b_col, b_row;

    conv_capture #(.W(4), .H(3), .FRAME_PIX(FP_B), .AW(16)) u_b (
        .i_clk       (clk),
        .i_reset     (b_reset),
        .i_start     (b_start),
        .i_pxl_in    (b_pxl),
        .i_valid_in  (b_valid),
        .i_rd_en     (b_rd_en),
        .i_rd_addr   (b_rd_addr),
        .o_rd_data   (b_rd_data),
        .o_rd_valid  (b_rd_valid),
        .o_busy      (b_busy),
        .o_frame_done(b_frame_done),
        .o_ready     (b_ready),
        .o_pxl_count (b_pxl_count),
        .o_col       (b_col),
        .o_row       (b_row),
        .o_overflow  (b_overflow)
    );

    // ---------------- scoreboards
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int fd_a = 0;
    int fd_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    always @(negedge clk) begin
        if (a_frame_done) fd_a++;
        if (a_rd_valid) begin
            if (q_a.size() == 0) chk("a_unexpected_rd_valid", 1, 0);
            else chk("a_rd_data", int'(a_rd_data), int'(q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (b_frame_done) fd_b++;
        if (b_rd_valid) begin
            if (q_b.size() == 0) chk("b_unexpected_rd_valid", 1, 0);
            else chk("b_rd_data", int'(b_rd_data), int'(q_b.pop_front()));
        end
    end

    // inputs change only at negedge; step returns at the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_a(input int addr, input logic [7:0] exp);
        a_rd_en   = 1'b1;
        a_rd_addr = 16'(addr);
        q_a.push_back(exp);
        step();
        a_rd_en = 1'b0;
    endtask

    task automatic read_b(input int addr, input logic [7:0] exp);
        b_rd_en   = 1'b1;
        b_rd_addr = 16'(addr);
        q_b.push_back(exp);
        step();
        b_rd_en = 1'b0;
    endtask

    logic [7:0] b_vals [0:9] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h12, 8'h7E, 8'hC3, 8'h5A, 8'h01, 8'hE7};
    int         b_gaps [0:9] = '{0, 2, 0, 1, 3, 0, 0, 5, 1, 2};

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_valid = 1'b1; a_rd_en = 1'b0; a_pxl = 8'h55; a_rd_addr = '0;
        b_reset = 1'b0; b_start = 1'b0; b_valid = 1'b1; b_rd_en = 1'b0; b_pxl = 8'h55; b_rd_addr = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_rd_data",    int'(a_rd_data), 0);
        chk("rst_rd_valid",   int'(a_rd_valid), 0);
        chk("rst_busy",       int'(a_busy), 0);
        chk("rst_frame_done", int'(a_frame_done), 0);
        chk("rst_ready",      int'(a_ready), 0);
        chk("rst_pxl_count",  int'(a_pxl_count), 0);
        chk("rst_col_row",    int'({a_col, a_row}), 0);
        chk("rst_overflow",   int'(a_overflow), 0);

        // valid_in in IDLE is ignored and raises no overflow
        a_reset = 1'b1; b_reset = 1'b1;
        step();
        chk("idle_valid_no_overflow", int'(a_overflow), 0);
        chk("idle_valid_no_count",    int'(a_pxl_count), 0);
        a_valid = 1'b0; b_valid = 1'b0;

        // ---- full frame on A
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("armed_busy", int'(a_busy), 1);
        for (int i = 0; i < FP_A; i++) begin
            a_valid = 1'b1;
            a_pxl   = 8'(i);
            a_rd_en = (i == 500);
            if (i == 1000) a_start = 1'b1;
            step();
            a_rd_en = 1'b0;
            a_start = 1'b0;
            if (i == 500)  chk("rd_in_capture_ignored", int'(a_rd_valid), 0);
            if (i == 1000) chk("start_in_capture_ignored", int'(a_pxl_count), 1001);
            if (i == FP_A - 2) chk("frame_done_not_early", int'(a_frame_done), 0);
        end
        chk("frame_done_pulse", int'(a_frame_done), 1);
        chk("done_pxl_count", int'(a_pxl_count), FP_A);
        a_valid = 1'b0;
        step();
        chk("frame_done_one_cycle", int'(a_frame_done), 0);
        chk("done_ready", int'(a_ready), 1);
        chk("done_busy", int'(a_busy), 0);
        chk("done_col", int'(a_col), 0);
        chk("done_row", int'(a_row), 218);
        chk("frame_done_count", fd_a, 1);

        read_a(0, 8'h00);
        read_a(255, 8'hFF);
        read_a(FP_A - 1, 8'h57);
        read_a(FP_A, 8'h00);
        step();
        chk("a_rd_valid_drops", int'(a_rd_valid), 0);
        chk("a_reads_drained", q_a.size(), 0);

        // ---- overflow in DONE, buffer untouched
        a_valid = 1'b1; a_pxl = 8'hAA;
        repeat (3) step();
        a_valid = 1'b0;
        chk("overflow_set", int'(a_overflow), 1);
        chk("overflow_count_hold", int'(a_pxl_count), FP_A);
        step();
        chk("overflow_sticky", int'(a_overflow), 1);
        read_a(0, 8'h00);
        read_a(1, 8'h01);
        read_a(2, 8'h02);
        step();
        chk("a_reads_drained2", q_a.size(), 0);

        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("rearm_overflow", int'(a_overflow), 0);
        chk("rearm_ready", int'(a_ready), 0);
        chk("rearm_busy", int'(a_busy), 1);
        chk("rearm_pxl_count", int'(a_pxl_count), 0);

        // ---- reset mid-capture
        for (int i = 0; i < 100; i++) begin
            a_valid = 1'b1;
            a_pxl   = 8'(i + 7);
            step();
        end
        chk("mid_pxl_count", int'(a_pxl_count), 100);
        a_reset = 1'b0;
        step();
        a_reset = 1'b1; a_valid = 1'b0;
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_pxl_count", int'(a_pxl_count), 0);
        chk("midrst_ready", int'(a_ready), 0);
        repeat (3) step();
        chk("midrst_no_frame_done", fd_a, 1);

        // ---- gapped small frame on B
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int k = 0; k < FP_B; k++) begin
            b_valid = 1'b0; b_pxl = 8'hEE;
            for (int g = 0; g < b_gaps[k]; g++) step();
            if (b_gaps[k] > 0) chk("b_gap_hold", int'(b_pxl_count), k);
            b_valid = 1'b1;
            b_pxl   = b_vals[k];
            step();
            chk("b_col", int'(b_col), (k + 1) % 4);
            chk("b_row", int'(b_row), (k + 1) / 4);
        end
        b_valid = 1'b0;
        chk("b_frame_done_pulse", int'(b_frame_done), 1);
        step();
        chk("b_ready", int'(b_ready), 1);
        chk("b_pxl_count", int'(b_pxl_count), FP_B);
        chk("b_frame_done_count", fd_b, 1);
        for (int k = 0; k < FP_B; k++) read_b(k, b_vals[k]);
        read_b(FP_B, 8'h00);
        step();
        chk("b_reads_drained", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
